// File: rtl/cdc_handshake_src_mc_if.sv
// Handshake bundle for the multi-channel CDC source endpoint.
// slave = endpoint side, master = local logic / far-domain side.
interface cdc_handshake_src_mc_if #(
  parameter int G_WIDTH    = 4,
  parameter int G_CHANNELS = 2
);
  logic [G_CHANNELS-1:0]         i_valid;
  logic [G_CHANNELS*G_WIDTH-1:0] i_data;
  logic [G_CHANNELS-1:0]         o_ready;
  logic [G_CHANNELS-1:0]         o_done;
  logic [G_CHANNELS-1:0]         o_req;
  logic [G_CHANNELS*G_WIDTH-1:0] o_data;
  logic [G_CHANNELS-1:0]         i_ack;
  logic [G_CHANNELS-1:0]         o_timeout;

  modport slave (
    input  i_valid, i_data, i_ack,
    output o_ready, o_done, o_req, o_data, o_timeout
  );

  modport master (
    output i_valid, i_data, i_ack,
    input  o_ready, o_done, o_req, o_data, o_timeout
  );
endinterface

// File: rtl/cdc_handshake_src_mc.sv
// Multi-channel source endpoint of a req/ack CDC handshake (2- or 4-phase).
// Optional per-channel abort timer enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_handshake_src_mc #(
  parameter int G_STAGES   = 2,
  parameter int G_WIDTH    = 4,
  parameter int G_CHANNELS = 2,
  parameter int G_MODE     = 0,
  parameter int G_TIMEOUT  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  cdc_handshake_src_mc_if.slave hs
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_HI = 2'd1,
    S_WAIT_LO = 2'd2
  } state_t;

  for (genvar c = 0; c < G_CHANNELS; c++) begin : g_ch
    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic [G_WIDTH-1:0]   data_q, data_d;
    logic [G_STAGES-1:0]  sync_q;
    logic                 ack_s;
    logic                 accept;
    logic                 abort;

    assign ack_s  = sync_q[G_STAGES-1];
    assign accept = hs.i_valid[c] && (state_q == S_IDLE);

    // bring the far-domain ack into i_clk
    always_ff @(posedge i_clk) begin
      if (i_rst) sync_q <= '0;
      else       sync_q <= {sync_q[G_STAGES-2:0], hs.i_ack[c]};
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam int TW = (G_TIMEOUT > 2) ? $clog2(G_TIMEOUT) : 1;
    logic [TW-1:0] cnt_q;

    assign abort = (cnt_q == TW'(G_TIMEOUT - 1));

    // wait-cycle counter; restarts on accept and after each abort
    always_ff @(posedge i_clk) begin
      if (i_rst || accept || tmo_d) cnt_q <= '0;
      else if (state_q != S_IDLE)   cnt_q <= cnt_q + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = (G_TIMEOUT < 2);
    assign abort      = 1'b0;
`endif

    // next state: accept in IDLE, then wait for synchronised ack
    always_comb begin
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (hs.i_valid[c]) begin
            data_d  = hs.i_data[c*G_WIDTH +: G_WIDTH];
            state_d = S_WAIT_HI;
            req_d   = (G_MODE == 0) ? ~req_q : 1'b1;
          end
        end
        S_WAIT_HI: begin
          if (G_MODE == 0) begin
            if (ack_s == req_q) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else if (abort) begin
              req_d   = ack_s;
              state_d = S_IDLE;
              tmo_d   = 1'b1;
            end
          end else begin
            if (ack_s) begin
              state_d = S_WAIT_LO;
              req_d   = 1'b0;
            end else if (abort) begin
              state_d = S_WAIT_LO;
              req_d   = 1'b0;
              tmo_d   = 1'b1;
            end
          end
        end
        S_WAIT_LO: begin
          if (!ack_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (abort) begin
            tmo_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // channel state and registered outputs
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        state_q <= S_IDLE;
        req_q   <= 1'b0;
        data_q  <= '0;
        done_q  <= 1'b0;
        tmo_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        req_q   <= req_d;
        data_q  <= data_d;
        done_q  <= done_d;
        tmo_q   <= tmo_d;
      end
    end

    assign hs.o_ready[c]   = (state_q == S_IDLE) && !i_rst;
    assign hs.o_req[c]     = req_q;
    assign hs.o_done[c]    = done_q;
    assign hs.o_timeout[c] = tmo_q;
    assign hs.o_data[c*G_WIDTH +: G_WIDTH] = data_q;

    // a 2-phase channel at rest must see ack equal to its request
    if (G_MODE == 0) begin : g_chk
      a_idle_ack: assert property (
        @(posedge i_clk) disable iff (i_rst)
        (state_q == S_IDLE) |-> (ack_s == req_q)
      );
    end
  end

endmodule

// File: tb/tb_cdc_handshake_src_mc.sv
// Bench for cdc_handshake_src_mc: a 2-phase and a 4-phase instance.
// Per-cycle transfer model plus directed literal checks.
module tb_cdc_handshake_src_mc;
  localparam int S = 2;
  localparam int T = 16;
`ifdef CDC_HS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] v0 = '0, v1 = '0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [1:0] lb0 = 2'b11, lb1 = 2'b11;
  logic [1:0] man0 = '0, man1 = '0;

  cdc_handshake_src_mc_if #(.G_WIDTH(4), .G_CHANNELS(2)) if0 ();
  cdc_handshake_src_mc_if #(.G_WIDTH(4), .G_CHANNELS(2)) if1 ();

  assign if0.i_valid = v0;
  assign if0.i_data  = d0;
  assign if0.i_ack   = (lb0 & if0.o_req) | (~lb0 & man0);
  assign if1.i_valid = v1;
  assign if1.i_data  = d1;
  assign if1.i_ack   = (lb1 & if1.o_req) | (~lb1 & man1);

  cdc_handshake_src_mc #(
    .G_STAGES(S), .G_WIDTH(4), .G_CHANNELS(2),
    .G_MODE(0), .G_TIMEOUT(T)
  ) u0 (.i_clk(clk), .i_rst(rst), .hs(if0));

  cdc_handshake_src_mc #(
    .G_STAGES(S), .G_WIDTH(4), .G_CHANNELS(2),
    .G_MODE(1), .G_TIMEOUT(T)
  ) u1 (.i_clk(clk), .i_rst(rst), .hs(if1));

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int nd[2][2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // transfer model: busy flag, request level, held data, 4-phase step
  bit         m_busy[2][2];
  bit         m_req[2][2];
  bit         m_ph[2][2];
  bit         m_done[2][2];
  bit         m_tmo[2][2];
  logic [3:0] m_data[2][2];
  int         m_cnt[2][2];
  bit         ah[2][2][$];

  logic       s_rst;
  logic [1:0] s_v[2];
  logic [7:0] s_d[2];
  logic [1:0] s_a[2];

  task automatic model_step();
    bit as, hit;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        m_done[d][c] = 0;
        m_tmo[d][c]  = 0;
        if (s_rst) begin
          m_busy[d][c] = 0; m_req[d][c] = 0; m_ph[d][c] = 0;
          m_data[d][c] = '0; m_cnt[d][c] = 0;
          ah[d][c].delete();
          repeat (S) ah[d][c].push_back(1'b0);
        end else begin
          as = ah[d][c].pop_front();
          ah[d][c].push_back(s_a[d][c]);
          hit = TMO_EN && (m_cnt[d][c] == T - 1);
          if (!m_busy[d][c]) begin
            if (s_v[d][c]) begin
              m_busy[d][c] = 1;
              m_data[d][c] = s_d[d][c*4 +: 4];
              m_req[d][c]  = (d == 0) ? !m_req[d][c] : 1'b1;
              m_ph[d][c]   = 0;
              m_cnt[d][c]  = 0;
            end
          end else begin
            if (d == 0) begin
              if (as == m_req[d][c]) begin
                m_busy[d][c] = 0; m_done[d][c] = 1;
              end else if (hit) begin
                m_req[d][c] = as; m_busy[d][c] = 0; m_tmo[d][c] = 1;
              end
            end else if (!m_ph[d][c]) begin
              if (as) begin
                m_ph[d][c] = 1; m_req[d][c] = 0;
              end else if (hit) begin
                m_ph[d][c] = 1; m_req[d][c] = 0; m_tmo[d][c] = 1;
              end
            end else begin
              if (!as) begin
                m_busy[d][c] = 0; m_done[d][c] = 1;
              end else if (hit) begin
                m_tmo[d][c] = 1;
              end
            end
            m_cnt[d][c] = m_tmo[d][c] ? 0 : m_cnt[d][c] + 1;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [1:0] er, ed, eq, et, ar, ad, aq, at;
    logic [7:0] edt, adt;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        er[c] = !m_busy[d][c] && !s_rst;
        ed[c] = m_done[d][c];
        eq[c] = m_req[d][c];
        et[c] = m_tmo[d][c];
        edt[c*4 +: 4] = m_data[d][c];
      end
      ar  = (d == 0) ? if0.o_ready   : if1.o_ready;
      ad  = (d == 0) ? if0.o_done    : if1.o_done;
      aq  = (d == 0) ? if0.o_req     : if1.o_req;
      at  = (d == 0) ? if0.o_timeout : if1.o_timeout;
      adt = (d == 0) ? if0.o_data    : if1.o_data;
      for (int c = 0; c < 2; c++) nd[d][c] += int'(ad[c]);
      chk($sformatf("u%0d_ready@%0d", d, cyc), 32'(ar), 32'(er));
      chk($sformatf("u%0d_done@%0d", d, cyc), 32'(ad), 32'(ed));
      chk($sformatf("u%0d_req@%0d", d, cyc), 32'(aq), 32'(eq));
      chk($sformatf("u%0d_tmo@%0d", d, cyc), 32'(at), 32'(et));
      chk($sformatf("u%0d_data@%0d", d, cyc), 32'(adt), 32'(edt));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        m_busy[d][c] = 0; m_req[d][c] = 0; m_ph[d][c] = 0;
        m_data[d][c] = '0; m_cnt[d][c] = 0; nd[d][c] = 0;
        repeat (S) ah[d][c].push_back(1'b0);
      end
    forever begin
      @(negedge clk);
      #4;
      s_rst = rst;
      s_v[0] = v0; s_v[1] = v1;
      s_d[0] = d0; s_d[1] = d1;
      s_a[0] = if0.i_ack; s_a[1] = if1.i_ack;
      @(posedge clk);
      #1;
      model_step();
      compare();
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int t0, t1, hi, base0, base1;
    bit ok;
    logic [7:0] tbl [4];
    tbl[0] = 8'h12; tbl[1] = 8'h34; tbl[2] = 8'h56; tbl[3] = 8'h78;

    // reset held three cycles with valid asserted
    rst = 1'b1; v0 = 2'b11; v1 = 2'b11; d0 = 8'hFF; d1 = 8'hFF;
    nclk(3);
    chk("t1_req0", 32'(if0.o_req), 0);
    chk("t1_req1", 32'(if1.o_req), 0);
    chk("t1_data0", 32'(if0.o_data), 0);
    chk("t1_data1", 32'(if1.o_data), 0);
    chk("t1_rdy0", 32'(if0.o_ready), 0);
    chk("t1_rdy1", 32'(if1.o_ready), 0);
    rst = 1'b0; v0 = '0; v1 = '0;
    #1;
    chk("t1_rdy0_after", 32'(if0.o_ready), 32'h3);
    chk("t1_rdy1_after", 32'(if1.o_ready), 32'h3);
    nclk(2);

    // 2-phase loopback, ch0 valid held, data A then 5
    base0 = nd[0][0];
    v0 = 2'b01; d0 = 8'h0A;
    nclk(1);
    chk("t2_req_first", 32'(if0.o_req[0]), 1);
    chk("t2_data_first", 32'(if0.o_data[3:0]), 32'hA);
    d0 = 8'h05;
    nclk(4);
    v0 = '0;
    nclk(6);
    chk("t2_data_second", 32'(if0.o_data[3:0]), 32'h5);
    chk("t2_req_back", 32'(if0.o_req[0]), 0);
    chk("t2_done_count", 32'(nd[0][0] - base0), 2);

    // 4-phase loopback ch1 single C; busy-time valid with 3 ignored
    v1 = 2'b10; d1 = 8'hC0;
    nclk(1);
    t0 = cyc; hi = 0; t1 = -1;
    v1 = 2'b10; d1 = 8'h30;
    for (int i = 0; i < 10; i++) begin
      if (if1.o_req[1]) hi++;
      if (if1.o_done[1] && t1 < 0) t1 = cyc;
      if (i == 2) v1 = '0;
      nclk(1);
    end
    chk("t3_req_high_cycles", 32'(hi), 3);
    chk("t3_done_latency", 32'(t1 - t0), 6);
    chk("t5_data_held", 32'(if1.o_data[7:4]), 32'hC);
    chk("t5_ready", 32'(if1.o_ready[1]), 1);

    // 2-phase, ch0 ack delayed, ch1 loopback
    lb0 = 2'b10; man0 = 2'b00;
    base1 = nd[0][1];
    v0 = 2'b11; d0 = 8'h96;
    nclk(1);
    v0 = '0;
    nclk(9);
    chk("t4_ch0_busy", 32'(if0.o_ready[0]), 0);
    chk("t4_ch1_done", 32'(nd[0][1] - base1), 1);
    chk("t4_ch1_ready", 32'(if0.o_ready[1]), 1);
    man0 = 2'b01;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      nclk(1);
      if (if0.o_ready[0]) ok = 1;
    end
    chk("t4_ch0_ready", 32'(ok), 1);
    chk("t4_data", 32'(if0.o_data), 32'h96);

    // 4-phase, both channels valid held, changing data
    base0 = nd[1][0]; base1 = nd[1][1];
    for (int i = 0; i < 14; i++) begin
      v1 = 2'b11; d1 = tbl[i % 4];
      nclk(1);
    end
    v1 = '0;
    nclk(8);
    chk("tb_both_done0", 32'(nd[1][0] - base0), 2);
    chk("tb_both_done1", 32'(nd[1][1] - base1), 2);
    chk("tb_both_data", 32'(if1.o_data), 32'h78);

    // reset in the middle of a 4-phase transfer
    v1 = 2'b01; d1 = 8'h0F;
    nclk(1);
    v1 = '0;
    nclk(1);
    rst = 1'b1; man0 = 2'b00;
    nclk(2);
    rst = 1'b0;
    #1;
    chk("tr_req1", 32'(if1.o_req), 0);
    chk("tr_data1", 32'(if1.o_data), 0);
    chk("tr_rdy1", 32'(if1.o_ready), 32'h3);
    chk("tr_req0", 32'(if0.o_req), 0);
    nclk(4);

`ifdef CDC_HS_TIMEOUT_EN
    // 2-phase abort with ack stuck low
    base0 = nd[0][0];
    v0 = 2'b01; d0 = 8'h07;
    nclk(1);
    t0 = cyc; t1 = -1;
    v0 = '0;
    for (int i = 0; i < 30 && t1 < 0; i++) begin
      nclk(1);
      if (if0.o_timeout[0]) t1 = cyc;
    end
    chk("t6_tmo_latency", 32'(t1 - t0), 16);
    chk("t6_req_restored", 32'(if0.o_req[0]), 0);
    chk("t6_ready", 32'(if0.o_ready[0]), 1);
    chk("t6_no_done", 32'(nd[0][0] - base0), 0);
    nclk(3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
